// File: rtl/gps_clkgen_pkg.sv
// gps_clkgen_pkg: shared constants for the GPS clock/reset generator.
//   - default divider ratios and reset-hold count
//   - default NCO tuning word (10.23 MHz from a 50 MHz system clock)
//   - reset stretcher counter width
//   - cnt_width(): counter width for a modulo-n counter, never below 1 bit
package gps_clkgen_pkg;

    localparam int unsigned FastDivDefault = 2;
    localparam int unsigned SlowDivDefault = 10;
    localparam int unsigned RstHoldDefault = 4;
    localparam logic [31:0] NcoFtwDefault  = 32'd878750309;
    localparam int unsigned RstCntW        = 8;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gps_clk_gen_if.sv
// gps_clk_gen_if: clock/reset bundle driven by gps_clk_gen into the GPS code generators.
//   gps_clk_fast  fast code clock, 50% duty
//   gps_clk_slow  slow clock, edges aligned to gps_clk_fast rising edges
//   gps_rst       active-high, stretched GPS reset
// Modports: master (generator side), slave (consumer side).
interface gps_clk_gen_if;

    logic gps_clk_fast;
    logic gps_clk_slow;
    logic gps_rst;

    modport master (output gps_clk_fast, output gps_clk_slow, output gps_rst);
    modport slave  (input  gps_clk_fast, input  gps_clk_slow, input  gps_rst);

endinterface

// File: rtl/gps_rst_sync.sv
// gps_rst_sync: 2-flop reset synchronizer, asynchronous assert / synchronous deassert.
//   clk         destination clock
//   rst_n       raw asynchronous active-low reset
//   rst_n_sync  synchronized active-low reset, rises on the 2nd clk edge after rst_n rises
module gps_rst_sync (
    input  logic clk,
    input  logic rst_n,
    output logic rst_n_sync
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= 1'b1;
            sync_q <= meta_q;
        end
    end

    assign rst_n_sync = sync_q;

endmodule

// File: rtl/gps_clk_gen.sv
// gps_clk_gen: clock/reset generator for the GPS core.
//   sys_clk_50  system clock, the only clock in this block
//   rst_n       asynchronous active-low reset
//   clk_bus     gps_clk_gen_if.master: gps_clk_fast, gps_clk_slow, gps_rst
// All outputs are flops in the sys_clk_50 domain. gps_clk_slow toggles only in cycles where
// gps_clk_fast rises; gps_rst falls on the RST_HOLD-th rising edge of gps_clk_slow.
// Build option: define GPS_CLKGEN_NCO_EN to replace the integer fast divider with a 32-bit
// phase accumulator (gps_clk_fast = acc[31], acc += NCO_FTW per cycle).
module gps_clk_gen
    import gps_clkgen_pkg::*;
#(
    parameter int unsigned FAST_DIV = FastDivDefault,
    parameter int unsigned SLOW_DIV = SlowDivDefault,
    parameter int unsigned RST_HOLD = RstHoldDefault
`ifdef GPS_CLKGEN_NCO_EN
    ,
    parameter logic [31:0] NCO_FTW  = NcoFtwDefault
`endif
) (
    input  logic           sys_clk_50,
    input  logic           rst_n,
    gps_clk_gen_if.master  clk_bus
);

    localparam int unsigned SlowHalf = SLOW_DIV / 2;
    localparam int unsigned SlowCntW = cnt_width(SlowHalf);

    // Dividers only count once the synchronized reset has released.
    logic run;

    gps_rst_sync u_rst_sync (
        .clk        (sys_clk_50),
        .rst_n      (rst_n),
        .rst_n_sync (run)
    );

    logic fast_q, fast_d;
    logic fast_rise;

`ifdef GPS_CLKGEN_NCO_EN
    logic [31:0] acc_q, acc_d;

    always_comb begin
        acc_d  = acc_q;
        fast_d = fast_q;
        if (run) begin
            acc_d  = acc_q + NCO_FTW;
            fast_d = acc_d[31];
        end
    end

    always_ff @(posedge sys_clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    localparam int unsigned FastHalf = FAST_DIV / 2;
    localparam int unsigned FastCntW = cnt_width(FastHalf);

    logic [FastCntW-1:0] fast_cnt_q, fast_cnt_d;

    always_comb begin
        fast_cnt_d = fast_cnt_q;
        fast_d     = fast_q;
        if (run) begin
            if (fast_cnt_q == FastCntW'(FastHalf - 1)) begin
                fast_cnt_d = '0;
                fast_d     = ~fast_q;
            end else begin
                fast_cnt_d = fast_cnt_q + FastCntW'(1);
            end
        end
    end

    always_ff @(posedge sys_clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            fast_cnt_q <= '0;
        end else begin
            fast_cnt_q <= fast_cnt_d;
        end
    end
`endif

    // Look-ahead on the fast flop so the slow flop can toggle in the same cycle.
    assign fast_rise = fast_d & ~fast_q;

    logic [SlowCntW-1:0] slow_cnt_q, slow_cnt_d;
    logic                slow_q, slow_d;
    logic                slow_rise;

    always_comb begin
        slow_cnt_d = slow_cnt_q;
        slow_d     = slow_q;
        if (fast_rise) begin
            if (slow_cnt_q == SlowCntW'(SlowHalf - 1)) begin
                slow_cnt_d = '0;
                slow_d     = ~slow_q;
            end else begin
                slow_cnt_d = slow_cnt_q + SlowCntW'(1);
            end
        end
    end

    assign slow_rise = slow_d & ~slow_q;

    // Stretcher only advances while gps_rst is high, so it stops at RST_HOLD.
    logic [RstCntW-1:0] rst_cnt_q, rst_cnt_d;
    logic               gps_rst_q, gps_rst_d;

    always_comb begin
        rst_cnt_d = rst_cnt_q;
        gps_rst_d = gps_rst_q;
        if (slow_rise && gps_rst_q) begin
            rst_cnt_d = rst_cnt_q + RstCntW'(1);
            if (rst_cnt_q == RstCntW'(RST_HOLD - 1)) begin
                gps_rst_d = 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            fast_q     <= 1'b0;
            slow_cnt_q <= '0;
            slow_q     <= 1'b0;
            rst_cnt_q  <= '0;
            gps_rst_q  <= 1'b1;
        end else begin
            fast_q     <= fast_d;
            slow_cnt_q <= slow_cnt_d;
            slow_q     <= slow_d;
            rst_cnt_q  <= rst_cnt_d;
            gps_rst_q  <= gps_rst_d;
        end
    end

    assign clk_bus.gps_clk_fast = fast_q;
    assign clk_bus.gps_clk_slow = slow_q;
    assign clk_bus.gps_rst      = gps_rst_q;

endmodule

// File: tb/tb_gps_clk_gen.sv
// tb_gps_clk_gen: self-checking bench for gps_clk_gen with default parameters.
// A cycle-count model derives the expected outputs from the number of sys_clk_50 rising
// edges since rst_n last rose; it is checked on every falling edge. Literal expectations pin
// the first fast rise, first slow rise and gps_rst release edges, and the asynchronous reset.
module tb_gps_clk_gen;

    localparam int unsigned FD = 2;
    localparam int unsigned SD = 10;
    localparam int unsigned RH = 4;

    logic clk;
    logic rst_n;
    logic check_en;
    int   edges;
    int   n_checks;
    int   n_pass;

    gps_clk_gen_if bus ();

    gps_clk_gen #(
        .FAST_DIV (FD),
        .SLOW_DIV (SD),
        .RST_HOLD (RH)
    ) dut (
        .sys_clk_50 (clk),
        .rst_n      (rst_n),
        .clk_bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Rising edges of sys_clk_50 seen since rst_n last went high.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Expected {fast, slow, rst} after n rising edges since release.
    // Run starts at edge 2; fast toggles every FD/2 run edges, slow toggles every SD/2 fast
    // rises, gps_rst holds until RH slow rises have happened.
    function automatic logic [2:0] model(input int n);
        int m, tog_f, rise_f, tog_s, rise_s;
        m      = (n > 2) ? n - 2 : 0;
        tog_f  = m / int'(FD / 2);
        rise_f = (tog_f + 1) / 2;
        tog_s  = rise_f / int'(SD / 2);
        rise_s = (tog_s + 1) / 2;
        return {tog_f[0], tog_s[0], (rise_s < int'(RH))};
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            logic [2:0] exp_v;
            exp_v = model(edges);
            check($sformatf("fast@edge%0d", edges), int'(bus.gps_clk_fast), int'(exp_v[2]));
            check($sformatf("slow@edge%0d", edges), int'(bus.gps_clk_slow), int'(exp_v[1]));
            check($sformatf("rst@edge%0d", edges),  int'(bus.gps_rst),      int'(exp_v[0]));
        end
    end

    task automatic check_reset_now(input string tag);
        check({tag, "_fast"}, int'(bus.gps_clk_fast), 0);
        check({tag, "_slow"}, int'(bus.gps_clk_slow), 0);
        check({tag, "_rst"},  int'(bus.gps_rst),      1);
    endtask

    task automatic release_rst();
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Drop rst_n between clock edges and confirm the outputs clear with no edge.
    task automatic drop_rst(input string tag);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_now(tag);
    endtask

    // Edge indices of the first fast high, first slow high and first gps_rst low.
    task automatic measure(input int ncyc, output int f_at, output int s_at, output int r_at);
        f_at = -1;
        s_at = -1;
        r_at = -1;
        repeat (ncyc) begin
            @(negedge clk);
            if (bus.gps_clk_fast && f_at < 0) f_at = edges;
            if (bus.gps_clk_slow && s_at < 0) s_at = edges;
            if (!bus.gps_rst && r_at < 0)     r_at = edges;
        end
    endtask

    task automatic check_sequence(input string tag);
        int f_at, s_at, r_at;
        measure(120, f_at, s_at, r_at);
        check({tag, "_first_fast_edge"}, f_at, 3);
        check({tag, "_first_slow_edge"}, s_at, 11);
        check({tag, "_rst_fall_edge"},   r_at, 71);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        check_en = 1'b0;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_reset_now("por");
`ifndef GPS_CLKGEN_NCO_EN
        check_en = 1'b1;
`endif
        repeat (32) @(negedge clk);
        check_reset_now("held");

`ifdef GPS_CLKGEN_NCO_EN
        begin
            int rises;
            logic prev;
            rises = 0;
            release_rst();
            prev = bus.gps_clk_fast;
            repeat (100000) begin
                @(negedge clk);
                if (bus.gps_clk_fast && !prev) rises++;
                prev = bus.gps_clk_fast;
            end
            check("nco_rise_count_in_range", int'(rises >= 20459 && rises <= 20461), 1);
        end
`else
        release_rst();
        check_sequence("rel1");

        // Mid-operation reset, then a reset landing part-way into a slow period.
        drop_rst("mid1");
        repeat (32) @(negedge clk);
        release_rst();
        repeat (32) @(negedge clk);
        drop_rst("mid2");
        repeat (32) @(negedge clk);
        release_rst();
        check_sequence("rel2");

        // Sub-cycle glitch on rst_n still resets everything.
        repeat (37) @(negedge clk);
        drop_rst("glitch");
        #1 rst_n = 1'b1;
        check_sequence("rel3");
`endif

        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
